// File: rtl/ula_nibble_seq.sv
// Nibble-serial front-end for a 4-bit 74181-style slice: accepts a WIDTH-bit command and runs the slice LSB nibble first.
// Latency: WIDTH/4 cycles from accept to res_valid. The result is held until res_ready, and no new command is taken until then.
module ula_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_s,
    input  logic             req_m,
    input  logic             req_cin,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_cin,
    input  logic [3:0]       alu_f,
    input  logic             alu_cout,
    input  logic             alu_aeqb,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_f,
    output logic             res_cout,
    output logic             res_eq,
    output logic             res_zero
);

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("ula_nibble_seq: WIDTH must be a multiple of 4 and at least 4");
    end

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0]    LAST     = IW'(NIB - 1);
    localparam logic [WIDTH-1:0] NIB_MASK = WIDTH'(4'hF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_f;
    logic [3:0]       r_s;
    logic             r_m;
    logic             r_carry;
    logic [IW-1:0]    r_idx;
    logic             r_cout;
    logic             r_eq;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic             w_inv;
    logic [IW+1:0]    w_sh;
    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [WIDTH-1:0] w_f_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        res_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = RUN;
            end
            RUN: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_last   = (r_idx == LAST);

    // These select codes report Cn+4 complemented; undo that before chaining.
    always_comb begin
        w_inv = 1'b0;
        case (r_s)
            4'b0000, 4'b0010, 4'b0011,
            4'b0110, 4'b0111, 4'b1011: w_inv = 1'b1;
            default:                   w_inv = 1'b0;
        endcase
    end

    assign w_sh    = {r_idx, 2'b00};
    assign w_a_sh  = r_a >> w_sh;
    assign w_b_sh  = r_b >> w_sh;
    assign w_f_nxt = (r_f & ~(NIB_MASK << w_sh)) | (WIDTH'(alu_f) << w_sh);

    // Slice inputs come straight from state, so they hold their last values outside RUN.
    assign alu_a   = w_a_sh[3:0];
    assign alu_b   = w_b_sh[3:0];
    assign alu_s   = r_s;
    assign alu_m   = r_m;
    assign alu_cin = r_carry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_m     <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_f     <= '0;
            r_cout  <= 1'b0;
            r_eq    <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= req_a;
            r_b     <= req_b;
            r_s     <= req_s;
            r_m     <= req_m;
            r_carry <= req_cin;
            r_idx   <= '0;
            r_eq    <= 1'b1;
        end else if (r_state == RUN) begin
            r_f     <= w_f_nxt;
            r_eq    <= r_eq & alu_aeqb;
            r_carry <= r_m ? 1'b0 : (alu_cout ^ w_inv);
            if (w_last) begin
                r_cout <= alu_cout;
                r_zero <= (w_f_nxt == '0);
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign res_f    = r_f;
    assign res_cout = r_cout;
    assign res_eq   = r_eq;
    assign res_zero = r_zero;

endmodule

// File: tb/tb_ula_nibble_seq.sv
// Directed bench for ula_nibble_seq with a behavioural 74181-style slice beside it.
module tb_ula_nibble_seq;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [3:0]       req_s;
    logic             req_m;
    logic             req_cin;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [3:0]       alu_s;
    logic             alu_m;
    logic             alu_cin;
    logic [3:0]       alu_f;
    logic             alu_cout;
    logic             alu_aeqb;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_f;
    logic             res_cout;
    logic             res_eq;
    logic             res_zero;

    int checks = 0;
    int errors = 0;

    logic [3:0] g_cins;
    logic [3:0] g_couts;

    ula_nibble_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m), .req_cin(req_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
        .alu_f(alu_f), .alu_cout(alu_cout), .alu_aeqb(alu_aeqb),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_f(res_f), .res_cout(res_cout), .res_eq(res_eq), .res_zero(res_zero)
    );

    always #5 clk = ~clk;

    // Slice model: active-high data, carry-in adds +1, Cn+4 complemented for the subtract-like codes.
    logic [3:0] m_x;
    logic [3:0] m_y;
    logic [4:0] m_sum;
    logic       m_inv;
    always_comb begin
        m_x   = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
        m_y   = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
        m_sum = {1'b0, m_x} + {1'b0, m_y} + {4'b0000, alu_cin};
        m_inv = (alu_s == 4'b0000) || (alu_s == 4'b0010) || (alu_s == 4'b0011) ||
                (alu_s == 4'b0110) || (alu_s == 4'b0111) || (alu_s == 4'b1011);
        if (alu_m) begin
            alu_f    = ~(m_x ^ m_y);
            alu_cout = 1'b0;
        end else begin
            alu_f    = m_sum[3:0];
            alu_cout = m_sum[4] ^ m_inv;
        end
        alu_aeqb = (alu_a == alu_b);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Entered just after a falling edge; leaves the DUT in DONE just after a falling edge.
    task automatic run_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                           input logic m, input logic cin);
        req_a     = a;
        req_b     = b;
        req_s     = s;
        req_m     = m;
        req_cin   = cin;
        req_valid = 1'b1;
        chk("accept_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("run_no_valid", {31'd0, res_valid}, 32'd0);
            g_cins[k]  = alu_cin;
            g_couts[k] = alu_cout;
            @(negedge clk);
        end
        chk("latency_valid", {31'd0, res_valid}, 32'd1);
        chk("done_not_ready", {31'd0, req_ready}, 32'd0);
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("after_hs_valid", {31'd0, res_valid}, 32'd0);
        chk("after_hs_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        res_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_s     = '0;
        req_m     = 1'b0;
        req_cin   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_f", {16'd0, res_f}, 32'h0);
        chk("rst_res_cout", {31'd0, res_cout}, 32'd0);
        chk("rst_res_eq", {31'd0, res_eq}, 32'd0);
        chk("rst_res_zero", {31'd0, res_zero}, 32'd0);
        chk("rst_alu_ab", {24'd0, alu_a, alu_b}, 32'h0);
        chk("rst_alu_cin", {31'd0, alu_cin}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Add with ripple through two nibbles
        run_cmd(16'h12FF, 16'h0001, 4'b1001, 1'b0, 1'b0);
        chk("add_f", {16'd0, res_f}, 32'h1300);
        chk("add_cout", {31'd0, res_cout}, 32'd0);
        chk("add_eq", {31'd0, res_eq}, 32'd0);
        chk("add_zero", {31'd0, res_zero}, 32'd0);
        chk("add_cins", {28'd0, g_cins}, 32'b0110);
        take_result();

        // Subtract: slice reports inverted carry, true carry must be chained
        run_cmd(16'h1000, 16'h0001, 4'b0110, 1'b0, 1'b1);
        chk("sub_f", {16'd0, res_f}, 32'h0FFF);
        chk("sub_cout", {31'd0, res_cout}, 32'd0);
        chk("sub_nib0_cout", {31'd0, g_couts[0]}, 32'd1);
        chk("sub_cins", {28'd0, g_cins}, 32'b0001);
        take_result();

        // Logic XOR
        run_cmd(16'hA5A5, 16'hFFFF, 4'b0110, 1'b1, 1'b1);
        chk("xor_f", {16'd0, res_f}, 32'h5A5A);
        chk("xor_cout", {31'd0, res_cout}, 32'd0);
        chk("xor_cins", {28'd0, g_cins}, 32'b0001);
        chk("xor_eq", {31'd0, res_eq}, 32'd0);
        chk("xor_zero", {31'd0, res_zero}, 32'd0);
        take_result();

        run_cmd(16'h3C3C, 16'h3C3C, 4'b0110, 1'b1, 1'b1);
        chk("xeq_f", {16'd0, res_f}, 32'h0000);
        chk("xeq_zero", {31'd0, res_zero}, 32'd1);
        chk("xeq_eq", {31'd0, res_eq}, 32'd1);
        take_result();

        // Backpressure in DONE, with a competing request that must be ignored
        run_cmd(16'h12FF, 16'h0001, 4'b1001, 1'b0, 1'b0);
        req_a     = 16'h5555;
        req_b     = 16'h5555;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, res_valid}, 32'd1);
            chk("bp_f", {16'd0, res_f}, 32'h1300);
            chk("bp_flags", {29'd0, res_cout, res_eq, res_zero}, 32'd0);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        take_result();

        // Reset during nibble 2
        req_a     = 16'h1234;
        req_b     = 16'h1234;
        req_s     = 4'b1001;
        req_m     = 1'b0;
        req_cin   = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("mrst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("mrst_res_f", {16'd0, res_f}, 32'h0);
        chk("mrst_flags", {29'd0, res_cout, res_eq, res_zero}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mrst_idle_valid", {31'd0, res_valid}, 32'd0);
        end
        run_cmd(16'h0123, 16'h0456, 4'b1001, 1'b0, 1'b0);
        chk("mrst_new_f", {16'd0, res_f}, 32'h0579);
        take_result();

        // Minus one, then minus one plus carry
        run_cmd(16'h4321, 16'h8765, 4'b0011, 1'b0, 1'b0);
        chk("m1_f", {16'd0, res_f}, 32'hFFFF);
        chk("m1_cout", {31'd0, res_cout}, 32'd1);
        chk("m1_zero", {31'd0, res_zero}, 32'd0);
        take_result();
        run_cmd(16'h4321, 16'h8765, 4'b0011, 1'b0, 1'b1);
        chk("m1c_f", {16'd0, res_f}, 32'h0000);
        chk("m1c_zero", {31'd0, res_zero}, 32'd1);
        chk("m1c_cout", {31'd0, res_cout}, 32'd0);
        take_result();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
